// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared constants and types for the instruction fetch unit
package riscv_fetch_pkg;
  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned PC_INC = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic {S_RUN, S_DRAIN} fetch_state_e;
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             inst;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with same-cycle push/pop (legal when full), flush and occupancy
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: pipelined instruction fetch with credit-limited requests and redirect draining.
// FETCH_PERF_EN adds a saturating fetch_stall_cnt output counting cycles without a valid instruction.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_stall_cnt
`endif
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = XLEN + 32;
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, aq_pc;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, occ, aq_cnt;
  logic [EW-1:0] ib_dout;
  logic aq_empty, aq_full, ib_empty, ib_full;
  logic run, fire, rsp, ib_push, ib_pop;
  assign run      = state_q == S_RUN;
  assign imem_req = reset && run && !redirect_valid && (32'(occ) + 32'(out_q) < FIFO_DEPTH);
  assign imem_addr = fetch_pc_q;
  assign fire     = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp      = imem_rvalid && out_q != '0;
  assign ib_push  = rsp && run && !redirect_valid;
  assign ib_pop   = inst_valid && inst_ready;
  assign inst_valid = !ib_empty;
  assign inst_pc    = inst_valid ? ib_dout[EW-1:32] : '0;
  assign inst_data  = inst_valid ? ib_dout[31:0] : '0;
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_addr_q (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (fire),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp && run),
    .data_o  (aq_pc),
    .count_o (aq_cnt),
    .empty_o (aq_empty),
    .full_o  (aq_full)
  );
  fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_inst_buf (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (ib_push),
    .data_i  ({aq_pc, imem_rdata}),
    .pop_i   (ib_pop),
    .data_o  (ib_dout),
    .count_o (occ),
    .empty_o (ib_empty),
    .full_o  (ib_full)
  );
  always_comb begin
    fetch_pc_d = fire ? fetch_pc_q + XLEN'(PC_INC) : fetch_pc_q;
    out_d      = out_q + CW'(fire) - CW'(rsp);
    drop_d     = run ? drop_q : drop_q - CW'(rsp);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      drop_d     = run ? out_q - CW'(rsp) : drop_d;
    end
    state_d = (drop_d != '0) ? S_DRAIN : S_RUN;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk)
    stall_q <= !reset ? '0 : stall_q + 32'(!inst_valid && stall_q != '1);
  assign fetch_stall_cnt = stall_q;
`endif
  a_rvalid_credit: assert property (@(posedge clk) disable iff (!reset) !(imem_rvalid && out_q == '0));
  a_aq_tracks_out: assert property (@(posedge clk) disable iff (!reset) !run || aq_cnt == out_q);
  a_aq_no_overrun: assert property (@(posedge clk) disable iff (!reset) !(fire && aq_full));
  a_aq_no_under:   assert property (@(posedge clk) disable iff (!reset) !(rsp && run && aq_empty));
  a_ib_no_overrun: assert property (@(posedge clk) disable iff (!reset) !(ib_push && ib_full && !ib_pop));
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed fetch scenarios with a 1-cycle memory model and an in-order scoreboard
module tb_riscv_fetch_unit;
  logic clk = 1'b0, reset = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic imem_req, inst_valid;
  logic [31:0] imem_addr, inst_data, inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_stall_cnt;
`endif
  always #5 clk = ~clk;
  riscv_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef FETCH_PERF_EN
    ,
    .fetch_stall_cnt(fetch_stall_cnt)
`endif
  );
  int total = 0, bad = 0, grants = 0, delivered = 0, d0 = 0, g0 = 0;
  logic hold = 1'b0, cap_first = 1'b0;
  logic [31:0] exp_next = '0, first_pc = '1;
  logic [63:0] sb [$];
  logic [31:0] mq [$];
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (!reset) begin
      sb.delete();
      mq.delete();
      exp_next = 32'h0;
    end else begin
      if (inst_valid && inst_ready) begin
        if (sb.size() == 0) chk("spurious_inst", inst_pc, 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("inst_pc", inst_pc, e[63:32]);
          chk("inst_data", inst_data, e[31:0]);
          delivered++;
          if (cap_first) begin
            first_pc  = inst_pc;
            cap_first = 1'b0;
          end
        end
      end
      if (redirect_valid) begin
        sb.delete();
        exp_next = {redirect_pc[31:2], 2'b00};
      end
      if (imem_req) chk("imem_addr", imem_addr, exp_next);
      if (imem_req && imem_gnt) begin
        sb.push_back({exp_next, inst_of(exp_next)});
        mq.push_back(imem_addr);
        exp_next += 32'd4;
        grants++;
      end
    end
    @(posedge clk);
    #1;
    imem_rvalid = !hold && mq.size() > 0;
    imem_rdata  = '0;
    if (imem_rvalid) imem_rdata = inst_of(mq.pop_front());
  endtask
  initial begin
    imem_gnt   = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    #3;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    reset = 1'b1;
    d0 = delivered;
    repeat (12) tick();
    chk("stream_count", 32'(delivered - d0 >= 6), 32'd1);
    inst_ready = 1'b0;
    g0 = grants;
    repeat (10) tick();
    #3;
    chk("bp_grants", 32'(grants - g0 <= 2), 32'd1);
    chk("bp_req_low", 32'(imem_req), 32'd0);
    chk("bp_valid_held", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    d0 = delivered;
    repeat (12) tick();
    chk("resume_count", 32'(delivered - d0 >= 6), 32'd1);
    hold = 1'b1;
    repeat (6) tick();
    #3;
    chk("two_out_req", 32'(imem_req), 32'd0);
    chk("two_out_valid", 32'(inst_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    #3;
    chk("redir_valid_low", 32'(inst_valid), 32'd0);
    chk("drain_req_low", 32'(imem_req), 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    hold      = 1'b0;
    cap_first = 1'b1;
    repeat (10) tick();
    chk("first_pc_100", first_pc, 32'h100);
    hold = 1'b1;
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    #3;
    chk("align_addr", imem_addr, 32'h200);
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    #3;
    chk("drain_redir_addr", imem_addr, 32'h400);
    chk("drain_redir_req", 32'(imem_req), 32'd0);
    hold      = 1'b0;
    cap_first = 1'b1;
    repeat (10) tick();
    chk("first_pc_400", first_pc, 32'h400);
    repeat (5) tick();
    reset          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h1234_5678;
    tick();
    redirect_valid = 1'b0;
    #3;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_data", inst_data, 32'h0);
    chk("mid_rst_pc", inst_pc, 32'h0);
    reset     = 1'b1;
    cap_first = 1'b1;
    d0        = delivered;
    repeat (10) tick();
    chk("restart_pc", first_pc, 32'h0);
    chk("restart_count", 32'(delivered - d0 >= 4), 32'd1);
`ifdef FETCH_PERF_EN
    reset    = 1'b0;
    imem_gnt = 1'b0;
    tick();
    reset = 1'b1;
    repeat (5) tick();
    #3;
    chk("perf_no_valid", 32'(inst_valid), 32'd0);
    chk("perf_stall_ge5", 32'(fetch_stall_cnt >= 32'd5), 32'd1);
    imem_gnt = 1'b1;
    repeat (6) tick();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
